suma_mult_datapath: RTL
=======================

Name: suma_mult_datapath

Overview:
- Datapath companion to the sum-of-multiples control FSM.
- Consumes the FSM's per-register clear/accumulate strobes (Rt/Mt, Rc/Mc, Rq/Mq, Rx/Mx, Rcont) and busy flag b.
- Maintains the partial-sum registers T (multiples of 3), C (multiples of 5), Q (multiples of 15), the final register X and the loop counter cont, all fed back to the FSM.
- Publishes a latched result with a one-cycle done pulse and a sticky overflow flag.

Parameters:
- W, 32, width of T, C, Q, X, result.
- CW, 16, width of n and cont.

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- n  in  CW  upper bound, exclusive; held stable by the host while b=1.
- Rt, Mt  in  1  T clear / T accumulate strobes.
- Rc, Mc  in  1  C clear / C accumulate strobes.
- Rq, Mq  in  1  Q clear / Q accumulate strobes.
- Rx, Mx  in  1  X clear / X final-load strobes.
- Rcont  in  1  0 = clear cont, 1 = increment cont.
- b  in  1  FSM busy flag.
- T, C, Q, X  out  W  partial-sum and final registers, fed back to the FSM.
- cont  out  CW  loop counter, fed back to the FSM.
- result  out  W  last completed sum.
- done  out  1  one-cycle pulse when result updates.
- ovf  out  1  sticky overflow flag for the current run.

Behaviour:
- Reset (rst_n=0, async): T, C, Q, X, cont, result, done, ovf, b_q all 0. Deassertion is sampled synchronously.
- cont: Rcont=0 → 0; Rcont=1 → cont+1, wraps modulo 2^CW.
- Term per cycle: k = cont+1 (current cont, before increment), computed at W bits.
  - term3 = 3k, term5 = 5k, term15 = 15k.
  - No truncation: 15*(2^CW) < 2^W at the defaults.
- T register:
  - Rt=1 → 0. Clear has priority over Mt.
  - Else Mt=1 and term3 < n (unsigned, strict) → T+term3.
  - Else hold. A term ≥ n is never added, even while Mt=1.
- C register: same rule using Rc/Mc and term5.
- Q register: same rule using Rq/Mq and term15.
- X register:
  - Rx=1 → 0. Priority over Mx.
  - Else Mx=1 → T+C−Q, modulo 2^W.
  - Else hold.
  - Uses the register values at the start of the cycle.
- Sums wrap modulo 2^W.
- ovf:
  - Set on carry-out of any T/C/Q accumulation.
  - Set on borrow of T+C−Q.
  - Cleared when Rt, Rc, Rq and Rx are all 1 in the same cycle (start-of-run clear).
  - If the clear and a set condition coincide, the clear wins.
- Completion: b_q is b registered. On the edge where b_q=1 and b=0, result ← X and done=1 for exactly one cycle; otherwise done=0.
- result holds until the next completion. It is not cleared by the start-of-run clear.
- Strobes are sampled only at clock edges; glitches between edges are ignored.
- Reset mid-run: all state returns to reset values immediately. No done pulse is issued for the aborted run.
- n changing while b=1 is unsupported; the result is undefined but no lock-up may occur.
- Latency: result is visible one cycle after the FSM's final-load cycle, i.e. on the cycle done=1.

Test Plan:
- Reset: assert rst_n=0 mid-accumulation (T=9) → T=C=Q=X=cont=result=0, done=0, ovf=0 asynchronously; no done pulse after release.
- n=10 driven through the full strobe sequence (clear, 4×T-acc, cont clear, 2×C-acc, final) → T=18, C=5, Q=0, X=23. The term 12 is excluded. done pulses once, result=23.
- n=16 → T=45, C=30, Q=15, X=60, result=60.
- n=3 (clear cycle then b drops) → X=0, done pulses, result=0, ovf=0.
- Priority: Rt=Mt=1 with T=18 → T=0. Rx=0, Mx=1 with T=5, C=0, Q=7 → X=0xFFFFFFFE and ovf=1.
- Overflow: preload T=0xFFFFFFFE, cont=0, n=100, Mt=1 → T=0x00000001 and ovf=1. A following all-R clear cycle → ovf=0.

Source files
------------

// File: rtl/suma_mult_datapath_if.sv
// Bundles the strobes and feedback registers exchanged between the
// sum-of-multiples control FSM (master) and its datapath (slave).
interface suma_mult_datapath_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic [CW-1:0] n;
    logic          Rt, Mt;
    logic          Rc, Mc;
    logic          Rq, Mq;
    logic          Rx, Mx;
    logic          Rcont;
    logic          b;
    logic [W-1:0]  T, C, Q, X;
    logic [CW-1:0] cont;
    logic [W-1:0]  result;
    logic          done;
    logic          ovf;

    modport master (
        output n, Rt, Mt, Rc, Mc, Rq, Mq, Rx, Mx, Rcont, b,
        input  T, C, Q, X, cont, result, done, ovf
    );

    modport slave (
        input  n, Rt, Mt, Rc, Mc, Rq, Mq, Rx, Mx, Rcont, b,
        output T, C, Q, X, cont, result, done, ovf
    );
endinterface

// File: rtl/suma_mult_datapath.sv
// Datapath for the sum of multiples of 3 or 5 below n: keeps the T/C/Q
// partial sums, forms X = T + C - Q, and latches the result when b falls.
module suma_mult_datapath #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    suma_mult_datapath_if.slave bus
);
    logic [W-1:0]  t_q, c_q, q_q, x_q, result_q;
    logic [CW-1:0] cont_q;
    logic          done_q, ovf_q, b_q;

    logic [W-1:0]  k, term3, term5, term15, n_w;
    logic [W:0]    sum_t, sum_c, sum_q, tc;
    logic          add_t, add_c, add_q, load_x, borrow;
    logic          start_clr, set_ovf, finish;

    // Terms use the counter value before this cycle's increment.
    always_comb begin
        k      = W'(cont_q) + W'(1);
        term3  = k * W'(3);
        term5  = k * W'(5);
        term15 = k * W'(15);
        n_w    = W'(bus.n);

        add_t  = !bus.Rt && bus.Mt && (term3  < n_w);
        add_c  = !bus.Rc && bus.Mc && (term5  < n_w);
        add_q  = !bus.Rq && bus.Mq && (term15 < n_w);
        load_x = !bus.Rx && bus.Mx;

        sum_t  = {1'b0, t_q} + {1'b0, term3};
        sum_c  = {1'b0, c_q} + {1'b0, term5};
        sum_q  = {1'b0, q_q} + {1'b0, term15};
        tc     = {1'b0, t_q} + {1'b0, c_q};
        borrow = tc < {1'b0, q_q};

        start_clr = bus.Rt && bus.Rc && bus.Rq && bus.Rx;
        set_ovf   = (add_t && sum_t[W]) || (add_c && sum_c[W]) ||
                    (add_q && sum_q[W]) || (load_x && borrow);
        finish    = b_q && !bus.b;
    end

    // Partial sums, final register and loop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q    <= '0;
            c_q    <= '0;
            q_q    <= '0;
            x_q    <= '0;
            cont_q <= '0;
        end else begin
            if (bus.Rt)     t_q <= '0;
            else if (add_t) t_q <= sum_t[W-1:0];

            if (bus.Rc)     c_q <= '0;
            else if (add_c) c_q <= sum_c[W-1:0];

            if (bus.Rq)     q_q <= '0;
            else if (add_q) q_q <= sum_q[W-1:0];

            if (bus.Rx)      x_q <= '0;
            else if (load_x) x_q <= t_q + c_q - q_q;

            if (bus.Rcont) cont_q <= cont_q + CW'(1);
            else           cont_q <= '0;
        end
    end

    // Completion and the sticky overflow flag; a start-of-run clear beats any set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            b_q    <= bus.b;
            done_q <= finish;
            if (finish) result_q <= x_q;

            if (start_clr)    ovf_q <= 1'b0;
            else if (set_ovf) ovf_q <= 1'b1;
        end
    end

    assign bus.T      = t_q;
    assign bus.C      = c_q;
    assign bus.Q      = q_q;
    assign bus.X      = x_q;
    assign bus.cont   = cont_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;
endmodule
